// File: rtl/div_pkg.sv
// Shared types and helpers for the serial restoring divider.
// Holds the op/state encodings and the absolute-value helper.
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  localparam int ABS_W = 64;

  // Callers zero-extend a narrower operand; the low bits of the negation are exact.
  function automatic logic [ABS_W-1:0] abs_val(
    input logic [ABS_W-1:0] v,
    input logic             neg
  );
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring shift-subtract iteration.
// Shifts {rem, quo} left, keeps the trial difference when it does not borrow.
module div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH:0]   rem_i,
  input  logic [DATA_WIDTH-1:0] quo_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH:0]   rem_o,
  output logic [DATA_WIDTH-1:0] quo_o
);

  localparam int W = DATA_WIDTH;

  logic [W+1:0] shifted;
  logic [W+1:0] trial;
  logic         borrow;

  always_comb begin
    shifted = {rem_i, quo_i[W-1]};
    trial   = shifted - {2'b00, divisor_i};
    borrow  = trial[W+1];
    rem_o   = borrow ? shifted[W:0] : trial[W:0];
    quo_o   = {quo_i[W-2:0], ~borrow};
  end

endmodule

// File: rtl/serial_divider.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit, one quotient bit per cycle.
// Define SERIAL_DIVIDER_FLUSH_EN to add the i_flush cancel port.
module serial_divider
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
`ifdef SERIAL_DIVIDER_FLUSH_EN
  input  logic                  i_flush,
`endif
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [1:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_div_by_zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [W-1:0]  MIN  = {1'b1, {(W-1){1'b0}}};

  logic flush;
`ifdef SERIAL_DIVIDER_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  div_state_e    state_q, state_d;
  div_op_e       op_q, op_d;
  logic [W:0]    rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  res_q, res_d;
  logic          dbz_q, dbz_d;

  logic [W:0]    step_rem;
  logic [W-1:0]  step_quo;

  div_step #(
    .DATA_WIDTH(W)
  ) u_step (
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .divisor_i(dvs_q),
    .rem_o    (step_rem),
    .quo_o    (step_quo)
  );

  logic         in_sgn;
  logic         in_rem;
  logic [W-1:0] dvd_abs;
  logic [W-1:0] dvs_abs;
  logic         q_rem;
  logic         q_neg;
  logic [W-1:0] q_sel;

  always_comb begin
    in_sgn  = ~i_op[0];
    in_rem  = i_op[1];
    dvd_abs = W'(abs_val(ABS_W'(i_dividend),
                         in_sgn & i_dividend[W-1]));
    dvs_abs = W'(abs_val(ABS_W'(i_divisor),
                         in_sgn & i_divisor[W-1]));
    q_rem   = op_q[1];
    q_neg   = ~op_q[0] & (q_rem ? rneg_q : qneg_q);
    q_sel   = q_rem ? step_rem[W-1:0] : step_quo;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          op_d   = div_op_e'(i_op);
          rem_d  = '0;
          quo_d  = dvd_abs;
          dvs_d  = dvs_abs;
          qneg_d = i_dividend[W-1] ^ i_divisor[W-1];
          rneg_d = i_dividend[W-1];
          cnt_d  = '0;
          dbz_d  = 1'b0;
          if (i_divisor == '0) begin
            res_d   = in_rem ? i_dividend : '1;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end else if (in_sgn && i_dividend == MIN
                       && (&i_divisor)) begin
            res_d   = in_rem ? '0 : MIN;
            state_d = ST_DONE;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          res_d   = q_neg ? -q_sel : q_sel;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_DIV;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
    end
  end

  assign o_ready       = (state_q == ST_IDLE);
  assign o_valid       = (state_q == ST_DONE);
  assign o_result      = res_q;
  assign o_div_by_zero = dbz_q;

endmodule
